// File: rtl/button_cmd_encoder.sv
// Turns two bouncing push-buttons into one-cycle commands on W (10 fwd, 01 back, 11 jump).
// Latency: 2-flop sync + DEBOUNCE_CYCLES + FSM (+COMBO_WIN when held alone); no backpressure, W is fire-and-forget.
module button_cmd_encoder #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int COMBO_WIN       = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_fwd,
  input  logic       btn_back,
  output logic [0:1] W
);

  localparam int CW = ($clog2(DEBOUNCE_CYCLES) < 1) ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam int WW = ($clog2(COMBO_WIN) < 1) ? 1 : $clog2(COMBO_WIN);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [WW-1:0] WIN_LAST = WW'(COMBO_WIN - 1);

  typedef enum logic [1:0] {IDLE, ARM, EMIT, RELEASE} state_t;

  // Bit 0 is forward, bit 1 is back throughout.
  logic [1:0] raw, sync1, s, db;

  assign raw = {btn_back, btn_fwd};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 2'b00;
      s     <= 2'b00;
    end else begin
      sync1 <= raw;
      s     <= sync1;
    end
  end

  genvar i;
  for (i = 0; i < 2; i++) begin : g_db
    logic [CW-1:0] cnt;
    logic          db_q;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        cnt  <= '0;
        db_q <= 1'b0;
      end else if (s[i] == db_q) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        db_q <= s[i];
        cnt  <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end

    assign db[i] = db_q;
  end

  logic db_fwd, db_back;
  assign db_fwd  = db[0];
  assign db_back = db[1];

  state_t        state, state_nxt;
  logic          rec_back, rec_back_nxt;
  logic [WW-1:0] win, win_nxt;
  logic [0:1]    w_nxt;
  logic          mine, other;
  logic [0:1]    rec_code;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      rec_back <= 1'b0;
      win      <= '0;
      W        <= 2'b00;
    end else begin
      state    <= state_nxt;
      rec_back <= rec_back_nxt;
      win      <= win_nxt;
      W        <= w_nxt;
    end
  end

  assign mine     = rec_back ? db_back : db_fwd;
  assign other    = rec_back ? db_fwd  : db_back;
  assign rec_code = rec_back ? 2'b01   : 2'b10;

  // w_nxt defaults to hold so W is non-zero only for the cycle spent in EMIT.
  always_comb begin
    state_nxt    = state;
    rec_back_nxt = rec_back;
    win_nxt      = win;
    w_nxt        = 2'b00;
    case (state)
      IDLE: begin
        if (db_fwd && db_back) begin
          state_nxt = EMIT;
          w_nxt     = 2'b11;
        end else if (db_fwd ^ db_back) begin
          state_nxt    = ARM;
          rec_back_nxt = db_back;
          win_nxt      = '0;
        end
      end
      ARM: begin
        if (other) begin
          state_nxt = EMIT;
          w_nxt     = 2'b11;
        end else if (!mine || (win == WIN_LAST)) begin
          state_nxt = EMIT;
          w_nxt     = rec_code;
        end else begin
          win_nxt = win + WW'(1);
        end
      end
      EMIT: state_nxt = RELEASE;
      RELEASE: begin
        if (!db_fwd && !db_back) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_button_cmd_encoder.sv
// Directed bench for button_cmd_encoder: default instance plus a COMBO_WIN=1 instance on the same buttons.
module tb_button_cmd_encoder;

  logic       clk;
  logic       reset;
  logic       btn_fwd;
  logic       btn_back;
  logic [0:1] w;
  logic [0:1] w1;

  int n_cmp = 0;
  int n_err = 0;

  button_cmd_encoder dut (
    .clk      (clk),
    .reset    (reset),
    .btn_fwd  (btn_fwd),
    .btn_back (btn_back),
    .W        (w)
  );

  button_cmd_encoder #(.DEBOUNCE_CYCLES(4), .COMBO_WIN(1)) dut1 (
    .clk      (clk),
    .reset    (reset),
    .btn_fwd  (btn_fwd),
    .btn_back (btn_back),
    .W        (w1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 ns after a rising edge; outputs are sampled at the same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    btn_fwd  = 1'b0;
    btn_back = 1'b0;
    repeat (20) tick();
  endtask

  task automatic test_reset();
    reset    = 1'b0;
    btn_fwd  = 1'b0;
    btn_back = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if (w !== 2'b00) begin
      n_err++;
      $display("FAIL reset_idle: W=%b expected 00", w);
    end
    btn_fwd = 1'b1;
    for (int e = 0; e < 10; e++) begin
      tick();
      n_cmp++;
      if (w !== 2'b00 || w1 !== 2'b00) begin
        n_err++;
        $display("FAIL reset_held edge %0d: W=%b W1=%b expected 00", e, w, w1);
      end
    end
    btn_fwd = 1'b0;
    reset   = 1'b1;
    settle();
  endtask

  task automatic test_single_hold();
    logic [0:1] exp;
    for (int e = 0; e < 40; e++) begin
      btn_fwd = 1'b1;
      tick();
      exp = (e == 14) ? 2'b10 : 2'b00;
      n_cmp++;
      if (w !== exp) begin
        n_err++;
        $display("FAIL single_hold edge %0d: W=%b expected %b", e, w, exp);
      end
    end
    settle();
  endtask

  task automatic test_both();
    logic [0:1] exp;
    for (int e = 0; e < 20; e++) begin
      btn_fwd  = 1'b1;
      btn_back = 1'b1;
      tick();
      exp = (e == 6) ? 2'b11 : 2'b00;
      n_cmp++;
      if (w !== exp || w1 !== exp) begin
        n_err++;
        $display("FAIL both edge %0d: W=%b W1=%b expected %b", e, w, w1, exp);
      end
    end
    settle();
  endtask

  task automatic test_combo();
    logic [0:1] exp;
    logic [0:1] exp1;
    for (int e = 0; e < 25; e++) begin
      btn_back = 1'b1;
      btn_fwd  = (e >= 3);
      tick();
      exp  = (e == 9) ? 2'b11 : 2'b00;
      exp1 = (e == 7) ? 2'b01 : 2'b00;
      n_cmp++;
      if (w !== exp) begin
        n_err++;
        $display("FAIL combo edge %0d: W=%b expected %b", e, w, exp);
      end
      n_cmp++;
      if (w1 !== exp1) begin
        n_err++;
        $display("FAIL combo_win1 edge %0d: W=%b expected %b", e, w1, exp1);
      end
    end
    settle();
  endtask

  task automatic test_late_second();
    logic [0:1] exp;
    for (int e = 0; e < 30; e++) begin
      btn_back = 1'b1;
      btn_fwd  = (e >= 12);
      tick();
      exp = (e == 14) ? 2'b01 : 2'b00;
      n_cmp++;
      if (w !== exp) begin
        n_err++;
        $display("FAIL late_second edge %0d: W=%b expected %b", e, w, exp);
      end
    end
    settle();
  endtask

  task automatic test_bounce();
    logic [0:1] exp;
    for (int e = 0; e < 30; e++) begin
      btn_fwd = (e < 10) && (e % 2 == 0);
      tick();
      n_cmp++;
      if (w !== 2'b00) begin
        n_err++;
        $display("FAIL bounce edge %0d: W=%b expected 00", e, w);
      end
    end
    for (int e = 0; e < 25; e++) begin
      btn_fwd = 1'b1;
      tick();
      exp = (e == 14) ? 2'b10 : 2'b00;
      n_cmp++;
      if (w !== exp) begin
        n_err++;
        $display("FAIL bounce_clean edge %0d: W=%b expected %b", e, w, exp);
      end
    end
    settle();
  endtask

  task automatic test_short_press();
    logic [0:1] exp;
    for (int e = 0; e < 25; e++) begin
      btn_back = (e < 6);
      tick();
      exp = (e == 12) ? 2'b01 : 2'b00;
      n_cmp++;
      if (w !== exp) begin
        n_err++;
        $display("FAIL short_press edge %0d: W=%b expected %b", e, w, exp);
      end
    end
    settle();
  endtask

  task automatic test_reset_arm();
    logic [0:1] exp;
    btn_fwd = 1'b1;
    repeat (8) tick();
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if (w !== 2'b00) begin
      n_err++;
      $display("FAIL reset_arm_async: W=%b expected 00", w);
    end
    repeat (3) tick();
    reset = 1'b1;
    for (int e = 0; e < 25; e++) begin
      tick();
      exp = (e == 14) ? 2'b10 : 2'b00;
      n_cmp++;
      if (w !== exp) begin
        n_err++;
        $display("FAIL reset_arm_rearm edge %0d: W=%b expected %b", e, w, exp);
      end
    end
    settle();
  endtask

  task automatic test_reset_emit();
    logic [0:1] exp;
    btn_fwd = 1'b1;
    repeat (15) tick();
    n_cmp++;
    if (w !== 2'b10) begin
      n_err++;
      $display("FAIL reset_emit_pre: W=%b expected 10", w);
    end
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if (w !== 2'b00) begin
      n_err++;
      $display("FAIL reset_emit_async: W=%b expected 00", w);
    end
    #2 reset = 1'b1;
    for (int e = 0; e < 20; e++) begin
      tick();
      exp = (e == 14) ? 2'b10 : 2'b00;
      n_cmp++;
      if (w !== exp) begin
        n_err++;
        $display("FAIL reset_emit_rearm edge %0d: W=%b expected %b", e, w, exp);
      end
    end
    settle();
  endtask

  initial begin
    reset    = 1'b0;
    btn_fwd  = 1'b0;
    btn_back = 1'b0;
    test_reset();
    test_single_hold();
    test_both();
    test_combo();
    test_late_second();
    test_bounce();
    test_short_press();
    test_reset_arm();
    test_reset_emit();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/button_cmd_encoder.md
# button_cmd_encoder

Front-end command encoder that turns two raw push-buttons (forward, back) into the 2-bit command bus `W` consumed by the downstream ten-state Moore sequencer. The block synchronises and debounces each button, detects presses, and resolves a "both pressed" combination within a time window. It emits exactly one single-cycle command per physical press: 10 forward, 01 back, 11 jump. `W` rests at 00 (hold) at all other times.

## Interface
- `DEBOUNCE_CYCLES`, 4: consecutive synchronised cycles a new level must persist before the debounced level changes (≥2).
- `COMBO_WIN`, 8: cycles after a single debounced press during which the other button upgrades the command to 11 (≥1).
- `clk`  in  1  rising-edge clock; single clock domain.
- `reset`  in  1  asynchronous, active-low reset.
- `btn_fwd`  in  1  raw forward button, active-high, asynchronous, may bounce.
- `btn_back`  in  1  raw back button, active-high, asynchronous, may bounce.
- `W`  out  [0:1]  registered command; `W[0]` is MSB. 00 hold, 10 forward, 01 back, 11 jump.

## Operation
- Synchroniser: 2 flops per button; `s_fwd`/`s_back` are the second flop.
- Debounce, per button: a counter clears whenever `s == db`; otherwise it increments. When the counter reaches `DEBOUNCE_CYCLES-1`:
  - `db <= s`;
  - the counter clears.
  - Counter width is `$clog2(DEBOUNCE_CYCLES)`, minimum 1.
- FSM states: IDLE, ARM, EMIT, RELEASE.
  - **IDLE**:
    - both `db` high → EMIT, code 11;
    - exactly one `db` high → ARM, record which button, `win <= 0`.
  - **ARM**, evaluated in priority order:
    - other `db` high → EMIT 11;
    - recorded `db` low (short press) → EMIT recorded code;
    - `win == COMBO_WIN-1` → EMIT recorded code;
    - otherwise `win++`.
  - **EMIT**: lasts one cycle → RELEASE.
  - **RELEASE**: stay until both `db` low → IDLE.
- `W` is a register:
  - loaded with the code on the edge that enters EMIT;
  - cleared to 00 on the edge that leaves EMIT;
  - 00 in every other state.
- Holding a button never repeats a command; a new command requires both debounced levels low first.
- A press of the second button while in RELEASE is ignored.
- Reset value of all flops is 0: synchronisers, `db`, counters, `win`, `W`=00, state IDLE.

## Timing
- Let edge 0 be the first rising edge that samples a clean press.
  - `s` is high after edge 1.
  - `db` is high after edge `1+DEBOUNCE_CYCLES`.
  - The FSM sees `db` on the next edge.
- Single held press: ARM after edge `2+D`. `W` = code during the cycle after edge `2+D+COMBO_WIN`, and 00 after the following edge. With defaults this is after edge 14, cleared after edge 15.
- Simultaneous clean press of both buttons: `W`=11 after edge `2+D` (edge 6 with defaults).
- Second button debounced high at ARM cycle `k < COMBO_WIN`: `W`=11 the cycle after that edge.
- Short press: `db` falls in ARM → recorded code is emitted on that edge; no wait for window expiry.
- Bounce: any excursion shorter than `DEBOUNCE_CYCLES` synchronised cycles leaves `db` unchanged.
- `W` is high for exactly 1 cycle per command.
- Reset asserted at any time:
  - `W`=00 immediately (asynchronous), state IDLE.
  - After deassertion, a still-held button is re-debounced from `db`=0 and produces a new command.
- `COMBO_WIN=1`: ARM emits the single code on its first evaluation unless the other button is already high.

## Test plan
- Clean `btn_fwd` held 40 cycles, defaults → `W`=10 exactly during the cycle after edge 14, 00 before and after. No repeat while held.
- `btn_fwd` and `btn_back` rise on the same cycle → `W`=11 for one cycle after edge 6, then 00. A single 11 until both are released.
- `btn_back` pressed, `btn_fwd` pressed 3 cycles later → `W`=11 once (not 01). A `btn_fwd` press 12 cycles after `btn_back` → `W`=01 only.
- Bounce: `btn_fwd` toggles 1-cycle high/low pulses for 10 cycles then settles low → `W` stays 00. Then a clean press → one 10.
- `btn_back` held 6 cycles (debounced, released before window expiry) → `W`=01 the cycle after `db_back` falls.
- `reset` pulled low while in ARM with `btn_fwd` held → `W`=00 asynchronously. After release with the button still held → one 10, 14 cycles after the first sampling edge.
